// File: rtl/vga_pkg.sv
// Shared constants and state encoding for the VGA timing decoder.
// Includes 800x600 reference timing, expressed in pixel clocks and lines.
package vga_pkg;

  localparam int CNT_WIDTH = 12;

  localparam int HOR_TOTAL_TIME  = 1056;
  localparam int HOR_BLANK_START = 800;
  localparam int HOR_BLANK_TIME  = 256;
  localparam int HOR_SYNC_START  = 840;
  localparam int HOR_SYNC_TIME   = 128;

  localparam int VER_TOTAL_TIME  = 628;
  localparam int VER_BLANK_START = 600;
  localparam int VER_BLANK_TIME  = 28;
  localparam int VER_SYNC_START  = 601;
  localparam int VER_SYNC_TIME   = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } dec_state_t;

endpackage

// File: rtl/vga_edge_det.sv
// Registers one signal; the delayed copy has 1-cycle latency.
// Rise/fall pulses are combinational against that delayed copy.
module vga_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic sig_dly,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk) begin
    if (!rst) sig_dly <= 1'b0;
    else      sig_dly <= sig_in;
  end

  assign rise = ~sig_dly & sig_in;
  assign fall = sig_dly & ~sig_in;

endmodule

// File: rtl/vga_timing_decoder.sv
// Recovers hcount/vcount from a sync/blank stream, measures line/frame totals and tracks lock.
// All outputs are registered, one cycle behind the inputs.
module vga_timing_decoder #(
  parameter int CNT_WIDTH   = vga_pkg::CNT_WIDTH,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 hblnk_in,
  input  logic                 vblnk_in,
  output logic [CNT_WIDTH-1:0] hcount,
  output logic [CNT_WIDTH-1:0] vcount,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 hblnk,
  output logic                 vblnk,
  output logic [CNT_WIDTH-1:0] h_total,
  output logic [CNT_WIDTH-1:0] v_total,
  output logic                 locked,
  output logic                 frame_start,
  output logic                 timing_err
);

  import vga_pkg::*;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [3:0]           LOCK_N  = 4'(LOCK_FRAMES);

  logic hb_rise, hb_fall, vb_rise, vb_fall;
  logic unused_edges;

  vga_edge_det u_hblnk (
    .clk(pclk), .rst(rst), .sig_in(hblnk_in),
    .sig_dly(hblnk), .rise(hb_rise), .fall(hb_fall)
  );

  vga_edge_det u_vblnk (
    .clk(pclk), .rst(rst), .sig_in(vblnk_in),
    .sig_dly(vblnk), .rise(vb_rise), .fall(vb_fall)
  );

  assign unused_edges = hb_rise | vb_rise;

  logic                 hfall, fend, timeout;
  logic [CNT_WIDTH-1:0] line_len, frame_len, ref_eff;
  logic                 line_ok;

  // A vblnk fall only counts when it lands on a line boundary.
  assign hfall     = hb_fall;
  assign fend      = hb_fall & vb_fall;
  assign timeout   = (hcount == CNT_MAX) & ~hfall;
  assign line_len  = hcount + 1'b1;
  assign frame_len = vcount + 1'b1;

  dec_state_t           state, state_nxt;
  logic [3:0]           match_cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] line_ref, ref_nxt;
  logic                 frame_ok, ok_nxt;
  logic                 first_line, first_nxt;
  logic [CNT_WIDTH-1:0] ht_nxt, vt_nxt;
  logic                 lock_nxt, err_nxt;

  assign line_ok = first_line | (line_len == line_ref);
  assign ref_eff = first_line ? line_len : line_ref;

  always_ff @(posedge pclk) begin
    if (!rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hsync_in;
      vsync       <= vsync_in;
      frame_start <= fend;
      if (hfall)                 hcount <= '0;
      else if (hcount != CNT_MAX) hcount <= hcount + 1'b1;
      if (fend)                            vcount <= '0;
      else if (hfall && vcount != CNT_MAX) vcount <= vcount + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = match_cnt;
    ref_nxt   = line_ref;
    ok_nxt    = frame_ok;
    first_nxt = first_line;
    ht_nxt    = h_total;
    vt_nxt    = v_total;
    lock_nxt  = locked;
    err_nxt   = 1'b0;

    if (timeout) begin
      state_nxt = SEARCH;
      lock_nxt  = 1'b0;
      cnt_nxt   = '0;
      err_nxt   = (state != SEARCH);
    end else if (hfall) begin
      case (state)
        SEARCH: begin
          if (fend) begin
            state_nxt = ACQUIRE;
            cnt_nxt   = '0;
            ok_nxt    = 1'b1;
            first_nxt = 1'b1;
          end
        end
        ACQUIRE: begin
          if (first_line) ref_nxt = line_len;
          first_nxt = 1'b0;
          if (fend) begin
            if (frame_ok && line_ok) begin
              ht_nxt  = ref_eff;
              vt_nxt  = frame_len;
              cnt_nxt = (ref_eff == h_total && frame_len == v_total) ? match_cnt + 4'd1 : 4'd1;
              if (cnt_nxt == LOCK_N) begin
                state_nxt = LOCKED;
                lock_nxt  = 1'b1;
              end
            end else begin
              cnt_nxt = '0;
            end
            ok_nxt    = 1'b1;
            first_nxt = 1'b1;
          end else if (!line_ok) begin
            ok_nxt = 1'b0;
          end
        end
        LOCKED: begin
          // A mid-frame loss leaves the rest of that frame unusable for reacquisition.
          if (line_len != h_total || (fend && frame_len != v_total)) begin
            state_nxt = ACQUIRE;
            lock_nxt  = 1'b0;
            cnt_nxt   = '0;
            err_nxt   = 1'b1;
          end
          ok_nxt    = fend;
          first_nxt = fend;
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state      <= SEARCH;
      match_cnt  <= '0;
      line_ref   <= '0;
      frame_ok   <= 1'b0;
      first_line <= 1'b0;
      h_total    <= '0;
      v_total    <= '0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      match_cnt  <= cnt_nxt;
      line_ref   <= ref_nxt;
      frame_ok   <= ok_nxt;
      first_line <= first_nxt;
      h_total    <= ht_nxt;
      v_total    <= vt_nxt;
      locked     <= lock_nxt;
      timing_err <= err_nxt;
    end
  end

endmodule
